// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: ROM read port on one side, instruction handshake to the core on the other.
// master is the fetch_queue side; slave is the ROM/core environment side.
interface fetch_queue_if #(
    parameter int PC_W = 10
);
    logic            rom_en;
    logic [PC_W-3:0] rom_addr;
    logic [31:0]     rom_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            halted;

    modport master (
        output rom_en, rom_addr, instr_valid, instr, instr_pc, halted,
        input  rom_data, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  rom_en, rom_addr, instr_valid, instr, instr_pc, halted,
        output rom_data, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: prefetches from a 1-cycle-latency ROM into a small FIFO,
// handles taken-branch redirects and stops permanently after consuming the halt opcode.
module fetch_queue #(
    parameter int DEPTH = 2,   // 2 or 4
    parameter int PC_W  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_queue_if.master   bus
);
    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W+1:0]   DEPTH_L = (PTR_W+2)'(DEPTH);
    localparam logic [6:0]         HALT_OP = 7'h7f;

    typedef enum logic {RUN, HALT} state_t;

    state_t            state, state_next;
    logic              armed;
    logic [PC_W-1:0]   fetch_pc;
    logic              inflight;
    logic [PC_W-1:0]   inflight_pc;

    logic [31:0]       q_instr [DEPTH];
    logic [PC_W-1:0]   q_pc    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;

    logic              valid;
    logic              handshake;
    logic              halting;
    logic              flush;
    logic              fetch_go;
    logic              write_en;
    logic [PTR_W+1:0]  demand;

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        valid      = 1'b0;
        handshake  = 1'b0;
        halting    = 1'b0;
        flush      = 1'b0;
        fetch_go   = 1'b0;
        write_en   = 1'b0;
        demand     = '0;
        case (state)
            RUN: begin
                valid     = (count != '0);
                handshake = valid && bus.instr_ready;
                halting   = handshake && (q_instr[rd_ptr][6:0] == HALT_OP);
                flush     = bus.redirect && !halting;
                // Slots already promised: what stays queued plus the response on its way.
                demand    = {1'b0, count} + (PTR_W+2)'(inflight) - (PTR_W+2)'(handshake);
                fetch_go  = armed && !bus.redirect && !halting && (demand < DEPTH_L);
                write_en  = inflight && !bus.redirect && !halting;
                if (halting) state_next = HALT;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = RUN;
        endcase
    end

    assign bus.rom_en      = fetch_go;
    assign bus.rom_addr    = fetch_pc[PC_W-1:2];
    assign bus.instr_valid = valid;
    assign bus.instr       = q_instr[rd_ptr];
    assign bus.instr_pc    = q_pc[rd_ptr];
    assign bus.halted      = (state == HALT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            armed       <= 1'b0;
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (state_next == HALT) begin
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else if (flush) begin
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= bus.redirect_pc & ~PC_W'(3);
            end else begin
                inflight <= fetch_go;
                if (fetch_go) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + PC_W'(4);
                end
                if (handshake) rd_ptr <= rd_ptr + PTR_W'(1);
                if (write_en)  wr_ptr <= wr_ptr + PTR_W'(1);
                count <= count + (PTR_W+1)'(write_en) - (PTR_W+1)'(handshake);
            end
        end
    end

    // NOTE: queue storage has no reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (write_en) begin
            q_instr[wr_ptr] <= bus.rom_data;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirect, wrap, mid-stream reset, halt.
module tb_fetch_queue;
    localparam int PC_W = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(PC_W)) bus ();

    fetch_queue #(.DEPTH(2), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int halt_idx = -1;

    function automatic logic [31:0] rom_word(int n);
        if (n == halt_idx) return 32'h0000_007f;
        return 32'h0000_0013 + (32'(n) << 7);
    endfunction

    // ROM with one cycle of read latency
    always @(posedge clk)
        bus.rom_data <= bus.rom_en ? rom_word(int'(bus.rom_addr)) : 32'hdead_beef;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.rom_en !== 1'b0) begin n_bad++; $display("FAIL reset_rom_en: got %0b want 0", bus.rom_en); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b want 0", bus.halted); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.rom_en !== 1'b1) begin n_bad++; $display("FAIL first_rom_en: got %0b want 1", bus.rom_en); end
        n_cmp++; if (bus.rom_addr !== 8'h00) begin n_bad++; $display("FAIL first_rom_addr: got %h want 00", bus.rom_addr); end
    endtask

    task automatic test_stream();
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid: got %0b want 0", bus.instr_valid); end
        n_cmp++; if (bus.rom_addr !== 8'h01 || bus.rom_en !== 1'b1) begin n_bad++; $display("FAIL stream_second_req: got en=%0b addr=%h want en=1 addr=01", bus.rom_en, bus.rom_addr); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'(4*k) || bus.instr !== 32'h13 + (32'(k) << 7)) begin
                n_bad++;
                $display("FAIL stream_%0d: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         k, bus.instr_valid, bus.instr_pc, bus.instr, 10'(4*k), 32'h13 + (32'(k) << 7));
            end
        end
    endtask

    task automatic test_backpressure();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h014 || bus.instr !== 32'h0000_0293 || bus.rom_en !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_%0d: got v=%0b pc=%h instr=%h en=%0b want v=1 pc=014 instr=00000293 en=0",
                         i, bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_en);
            end
            tick();
        end
        bus.instr_ready = 1'b1;
        #1;
        n_cmp++; if (bus.instr_pc !== 10'h014 || bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h07) begin n_bad++; $display("FAIL release: got pc=%h en=%0b addr=%h want pc=014 en=1 addr=07", bus.instr_pc, bus.rom_en, bus.rom_addr); end
        for (int k = 6; k < 9; k++) begin
            tick();
            n_cmp++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'(4*k) || bus.instr !== 32'h13 + (32'(k) << 7)) begin
                n_bad++;
                $display("FAIL after_stall_%0d: got v=%0b pc=%h instr=%h want v=1 pc=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 10'(4*k));
            end
        end
    endtask

    task automatic test_redirect();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h02a;
        #1;
        n_cmp++; if (bus.instr_pc !== 10'h004 || bus.rom_en !== 1'b0) begin n_bad++; $display("FAIL redir_cycle: got pc=%h en=%0b want pc=004 en=0", bus.instr_pc, bus.rom_en); end
        tick();
        bus.redirect = 1'b0;
        #1;
        n_cmp++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h0a) begin n_bad++; $display("FAIL redir_target_req: got en=%0b addr=%h want en=1 addr=0a", bus.rom_en, bus.rom_addr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_killed_a: got v=%0b pc=%h want v=0", bus.instr_valid, bus.instr_pc); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_killed_b: got v=%0b pc=%h want v=0", bus.instr_valid, bus.instr_pc); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h028 || bus.instr !== 32'h0000_0513) begin n_bad++; $display("FAIL redir_first: got v=%0b pc=%h instr=%h want v=1 pc=028 instr=00000513", bus.instr_valid, bus.instr_pc, bus.instr); end
        tick();
        n_cmp++; if (bus.instr_pc !== 10'h02c || bus.instr !== 32'h0000_0593) begin n_bad++; $display("FAIL redir_second: got pc=%h instr=%h want pc=02c instr=00000593", bus.instr_pc, bus.instr); end
    endtask

    task automatic test_wrap();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h3f8;
        tick();
        bus.redirect = 1'b0;
        #1;
        n_cmp++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 8'hfe) begin n_bad++; $display("FAIL wrap_req: got en=%0b addr=%h want en=1 addr=fe", bus.rom_en, bus.rom_addr); end
        tick();
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h3f8 || bus.instr !== 32'h0000_7f13) begin n_bad++; $display("FAIL wrap_3f8: got v=%0b pc=%h instr=%h want v=1 pc=3f8 instr=00007f13", bus.instr_valid, bus.instr_pc, bus.instr); end
        tick();
        n_cmp++; if (bus.instr_pc !== 10'h3fc || bus.instr !== 32'h0000_7f93) begin n_bad++; $display("FAIL wrap_3fc: got pc=%h instr=%h want pc=3fc instr=00007f93", bus.instr_pc, bus.instr); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h000 || bus.instr !== 32'h0000_0013) begin n_bad++; $display("FAIL wrap_000: got v=%0b pc=%h instr=%h want v=1 pc=000 instr=00000013", bus.instr_valid, bus.instr_pc, bus.instr); end
    endtask

    task automatic test_reset_midstream();
        bus.instr_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.rom_en !== 1'b0) begin n_bad++; $display("FAIL full_before_reset: got v=%0b en=%0b want v=1 en=0", bus.instr_valid, bus.rom_en); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.rom_en !== 1'b0) begin n_bad++; $display("FAIL async_reset: got v=%0b en=%0b want v=0 en=0", bus.instr_valid, bus.rom_en); end
        tick();
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        n_cmp++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h00) begin n_bad++; $display("FAIL restart_req: got en=%0b addr=%h want en=1 addr=00", bus.rom_en, bus.rom_addr); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL restart_stale: got v=%0b pc=%h want v=0", bus.instr_valid, bus.instr_pc); end
        tick();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 10'h000 || bus.instr !== 32'h0000_0013) begin n_bad++; $display("FAIL restart_first: got v=%0b pc=%h instr=%h want v=1 pc=000 instr=00000013", bus.instr_valid, bus.instr_pc, bus.instr); end
    endtask

    task automatic test_halt();
        halt_idx = 3;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h100;
        #1;
        n_cmp++; if (bus.instr_pc !== 10'h00c || bus.instr !== 32'h0000_007f || bus.halted !== 1'b0) begin n_bad++; $display("FAIL halt_head: got pc=%h instr=%h halted=%0b want pc=00c instr=0000007f halted=0", bus.instr_pc, bus.instr, bus.halted); end
        tick();
        n_cmp++; if ({bus.halted, bus.rom_en, bus.instr_valid} !== 3'b100) begin n_bad++; $display("FAIL halt_enter: got halted/en/v=%b want 100", {bus.halted, bus.rom_en, bus.instr_valid}); end
        for (int i = 0; i < 20; i++) begin
            bus.redirect    = (i % 2 == 0);
            bus.redirect_pc = 10'h040;
            #1;
            n_cmp++;
            if ({bus.halted, bus.rom_en, bus.instr_valid} !== 3'b100) begin
                n_bad++;
                $display("FAIL halt_hold_%0d: got halted/en/v=%b want 100", i, {bus.halted, bus.rom_en, bus.instr_valid});
            end
            tick();
        end
        bus.redirect = 1'b0;
        halt_idx = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midstream();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
